// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a one-entry output buffer and status flags.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       busy
);

    // Counter is widened only when 1.5 or 2 stop bits need more than 16 ticks.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         r_state, w_state_nxt;
    logic [SW-1:0]  r_s, w_s_nxt;
    logic [2:0]     r_n, w_n_nxt;
    logic [7:0]     r_b, w_b_nxt, w_b_shift;
    logic           r_sync1, r_rxs, r_rxs_d;
    logic           w_fall, w_done, w_perr;
    logic [7:0]     r_dout;
    logic           r_valid, r_done, r_frame_err, r_overrun;
`ifdef UART_RX_PARITY_EN
    logic           r_perr, w_perr_nxt, r_parity_err;
`endif

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~r_rxs;

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_done      = 1'b0;
        w_b_shift   = r_b >> 1;
        w_b_shift[DBIT-1] = r_rxs;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (!r_rxs) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_b_nxt = w_b_shift;
                        w_s_nxt = '0;
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_n_nxt = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_perr_nxt  = ((^r_b[DBIT-1:0]) ^ r_rxs) != PARITY_ODD;
                        w_state_nxt = STOP;
                        w_s_nxt     = '0;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_perr <= 1'b0;
        else       r_perr <= w_perr_nxt;
    end
    assign w_perr = r_perr;
`else
    assign w_perr = 1'b0;
`endif

    // A read in the completion cycle consumes the old byte, so it is not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_done) begin
                r_dout      <= r_b;
                r_frame_err <= ~r_rxs;
                r_valid     <= 1'b1;
                if (rd_en)        r_overrun <= 1'b0;
                else if (r_valid) r_overrun <= 1'b1;
            end else if (rd_en && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_parity_err <= 1'b0;
        else if (w_done) r_parity_err <= w_perr;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = w_perr;
`endif

    assign dout         = r_dout;
    assign rx_valid     = r_valid;
    assign rx_done_tick = r_done;
    assign frame_err    = r_frame_err;
    assign overrun_err  = r_overrun;
    assign busy         = (r_state != IDLE);

endmodule
